// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit path
package uart_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_DONE
   } feeder_state_t;

   localparam int UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous circular-buffer FIFO with explicit occupancy count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             overflow
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_nxt;
   logic             do_wr;
   logic             do_rd;

   // Acceptance uses the registered flags, so a pop never frees room for a same-cycle write.
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({do_wr, do_rd})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count    <= count_nxt;
         full     <= (count_nxt == (AW+1)'(DEPTH));
         empty    <= (count_nxt == '0);
         overflow <= wr_en && full;
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers bytes and launches them one at a time into the UART transmitter
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_100m,
   input  logic          rst_n,
   input  byte_t         wr_data,
   input  logic          wr_en,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output byte_t         data_in,
   output logic          En_btn,
   input  logic          tx_busy
);

   feeder_state_t state;
   byte_t         head;
   logic          pop;

   // Never launch while the transmitter is busy; this also covers a frame left running across reset.
   assign pop = (state == IDLE) && !empty && !tx_busy;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk      (clk_100m),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (head),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         data_in <= 8'h00;
         En_btn  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               En_btn <= 1'b0;
               if (pop) begin
                  data_in <= head;
                  En_btn  <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               if (tx_busy) begin
                  En_btn <= 1'b0;
                  state  <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               En_btn <= 1'b0;
               if (!tx_busy) begin
                  state <= IDLE;
               end
            end
            default: begin
               En_btn <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-buffering front end for the UART transmitter. It accepts bytes from on-chip logic through a simple write strobe and stores them in a synchronous FIFO. It then launches them one at a time into the transmitter's `data_in` / `En_btn` / `tx_busy` interface, so producers never have to track frame timing. It sits directly upstream of the `uart` top and shares its `clk_100m` domain.

## Interface
Parameters:
- `DEPTH`, 16, FIFO entries; power of two, minimum 2.
- `AW`, `$clog2(DEPTH)`, pointer width; derived, not overridden.

Ports:
- `clk_100m`  input  1  system clock; all logic is rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `wr_data`  input  8  byte to enqueue.
- `wr_en`  input  1  enqueue strobe; one byte per cycle high.
- `full`  output  1  FIFO holds `DEPTH` bytes.
- `empty`  output  1  FIFO holds 0 bytes.
- `count`  output  AW+1  current occupancy, 0..`DEPTH`.
- `overflow`  output  1  one-cycle pulse when a write is dropped.
- `data_in`  output  8  byte presented to the transmitter.
- `En_btn`  output  1  transmit request to the transmitter.
- `tx_busy`  input  1  transmitter busy flag.

## Operation
- FIFO: circular buffer with `wr_ptr` and `rd_ptr` of AW bits, wrapping modulo `DEPTH`; `count` is held explicitly.
- Write accepted iff `wr_en && !full`, with `full` sampled before the edge. A write while full is dropped, `overflow` pulses, and the contents are unchanged.
- Simultaneous write and pop: both occur and `count` is unchanged.
  - When full: the write is rejected even if a pop happens in the same cycle.
  - When empty: no pop occurs, and the written byte becomes poppable next cycle (no bypass).
- FSM states: `IDLE`, `START`, `WAIT_DONE`.
  - `IDLE`: `En_btn`=0. If `!empty && !tx_busy`, pop the head into the `data_in` register (`rd_ptr`+1, `count`-1) and go to `START`.
  - `START`: `En_btn`=1 and `data_in` held stable. When `tx_busy`=1, go to `WAIT_DONE`. There is no timeout; `En_btn` is held until `tx_busy` is seen.
  - `WAIT_DONE`: `En_btn`=0. When `tx_busy`=0, go to `IDLE`.
- `data_in` changes only on a pop and holds its last value otherwise.
- Bytes are transmitted in write order. No byte is lost or duplicated once accepted.
- Reset mid-operation: the FIFO is cleared and the FSM returns to `IDLE`. A frame already inside the transmitter completes on its own. `IDLE` does not launch while `tx_busy`=1, so no frame collision is possible.

## Timing
- Reset values: `data_in`=8'h00, `En_btn`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0. Pointers are 0 and the FSM is in `IDLE`.
- All outputs are registered. `full`, `empty` and `count` update on the edge that performs the write or pop.
- Latency with an empty FIFO and idle transmitter:
  - `wr_en` at edge N;
  - pop at edge N+1;
  - `En_btn` high from N+1 until the edge after `tx_busy` is first sampled high.
- Back-to-back frames: at least one `IDLE` cycle between `tx_busy` falling and the next `En_btn`.
- `overflow` is high for exactly the cycle following the dropped-write edge.

## Structure
- Shared package `uart_pkg`:
  - `byte_t` (logic [7:0]);
  - FSM enum `feeder_state_t` with values `IDLE`, `START`, `WAIT_DONE`;
  - default `UART_FIFO_DEPTH` = 16.
- One natural sub-module, `sync_fifo`, parameterised by width and depth. It provides the storage array, pointers, `count`, `full` and `empty`. The launch FSM stays in `uart_tx_feeder`.

## Test plan
- Reset with `wr_en` active: `empty`=1, `count`=0, `En_btn`=0. After release, write 8'hA5 → `En_btn` rises one cycle after the write edge with `data_in`=8'hA5. With the `uart` top attached, `tx` shows frame A5.
- Write 8'h01..8'h10 back-to-back with DEPTH=16 and the transmitter model holding `tx_busy`=1 → `full`=1 and `count`=16. Extra write 8'h55 → `overflow` pulses once and 8'h55 is never transmitted.
- Drain of the 16 bytes above → transmitted in order 01..10. `empty`=1 after the last pop, and the pointers wrap cleanly on a following burst of 20 writes.
- Simultaneous write and pop at `count`=3 → `count` stays 3. Write while full during a pop → dropped and `overflow`=1.
- Delay `tx_busy` rising by 5 cycles → `En_btn` held 5+ cycles and `data_in` is stable throughout. Exactly one frame is sent.
- Assert `rst_n` low during `WAIT_DONE` with 4 bytes queued → after release the queue is empty and `En_btn` stays 0 until new writes arrive and `tx_busy`=0.
